// File: rtl/logic_sweep_pkg.sv
// Shared types and helpers for the exhaustive logic sweep checker.
package logic_sweep_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Size of the input vector space for an n_in-input function.
   function automatic int nvec(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/logic_sweep_checker_sweep_counter.sv
// Vector and dwell counters: each vector is held DWELL cycles; sample_en marks the last one.
module sweep_counter
   import logic_sweep_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int DWELL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            en,
   output logic [N_IN-1:0] vec,
   output logic            sample_en,
   output logic            last
);

   localparam int NVEC = nvec(N_IN);
   localparam int VW   = N_IN + 1;
   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [VW-1:0]   V_LAST  = VW'(NVEC - 1);
   localparam logic [VW-1:0]   V_ONE   = VW'(1);
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
   localparam logic [DW_W-1:0] DW_ONE  = DW_W'(1);

   // One spare bit so the terminal vector is detected by compare, never by wrap.
   logic [VW-1:0]   r_vec;
   logic [DW_W-1:0] r_dwell;

   assign sample_en = (r_dwell == DW_LAST);
   assign last      = sample_en && (r_vec == V_LAST);
   assign vec       = r_vec[N_IN-1:0];

   // Advance dwell, then vector; hold on the final vector until cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec   <= '0;
         r_dwell <= '0;
      end else if (clr) begin
         r_vec   <= '0;
         r_dwell <= '0;
      end else if (en) begin
         if (!sample_en) begin
            r_dwell <= r_dwell + DW_ONE;
         end else if (!last) begin
            r_vec   <= r_vec + V_ONE;
            r_dwell <= '0;
         end else begin
            r_vec   <= r_vec;
            r_dwell <= r_dwell;
         end
      end else begin
         r_vec   <= r_vec;
         r_dwell <= r_dwell;
      end
   end

endmodule

// File: rtl/logic_sweep_checker.sv
// Exhaustive sweep checker: walks every input vector of an external function and
// compares its response with a latched expected truth table.
module logic_sweep_checker
   import logic_sweep_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int DWELL = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [(1<<N_IN)-1:0] exp_tt,
   input  logic                 dut_f,
   output logic [N_IN-1:0]      vec_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_cnt,
   output logic [N_IN-1:0]      first_err_vec,
   output logic                 first_err_valid
);

   localparam int NVEC = nvec(N_IN);
   localparam logic [N_IN:0] ERR_ONE = (N_IN+1)'(1);

   state_e            r_state;
   state_e            w_state_nxt;
   logic              w_clr;
   logic              w_en;
   logic              w_start_acc;
   logic              w_sample;
   logic              w_last;
   logic              w_mismatch;
   logic [N_IN-1:0]   w_vec;
   logic [N_IN:0]     w_err_nxt;
   logic [NVEC-1:0]   r_tt;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [N_IN:0]     r_err_cnt;
   logic [N_IN-1:0]   r_first_err_vec;
   logic              r_first_err_valid;

   sweep_counter #(
      .N_IN  (N_IN),
      .DWELL (DWELL)
   ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (w_clr),
      .en        (w_en),
      .vec       (w_vec),
      .sample_en (w_sample),
      .last      (w_last)
   );

   // abort outranks the sample taken on the same edge.
   assign w_en        = (r_state == RUN) && !abort;
   assign w_start_acc = ((r_state == IDLE) || (r_state == DONE)) && start;
   assign w_mismatch  = w_en && w_sample && (dut_f != r_tt[w_vec]);
   assign w_err_nxt   = r_err_cnt + (w_mismatch ? ERR_ONE : '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and counter clear.
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt = RUN;
               w_clr       = 1'b1;
            end else begin
               w_state_nxt = r_state;
            end
         end
         RUN: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_clr       = 1'b1;
            end else if (w_last) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_clr       = 1'b1;
         end
      endcase
   end

   // Table latch, status flags and error bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tt              <= '0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_err_cnt         <= '0;
         r_first_err_vec   <= '0;
         r_first_err_valid <= 1'b0;
      end else if (w_start_acc) begin
         r_tt              <= exp_tt;
         r_busy            <= 1'b1;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_err_cnt         <= '0;
         r_first_err_vec   <= '0;
         r_first_err_valid <= 1'b0;
      end else if (r_state == RUN) begin
         if (abort) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
         end else begin
            r_err_cnt <= w_err_nxt;
            if (w_mismatch && !r_first_err_valid) begin
               r_first_err_vec   <= w_vec;
               r_first_err_valid <= 1'b1;
            end else begin
               r_first_err_vec   <= r_first_err_vec;
               r_first_err_valid <= r_first_err_valid;
            end
            if (w_last) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= (w_err_nxt == '0);
            end else begin
               r_busy <= r_busy;
               r_done <= r_done;
               r_pass <= r_pass;
            end
         end
      end else begin
         r_busy <= r_busy;
         r_done <= r_done;
         r_pass <= r_pass;
      end
   end

   assign vec_out         = w_vec;
   assign busy            = r_busy;
   assign done            = r_done;
   assign pass            = r_pass;
   assign err_cnt         = r_err_cnt;
   assign first_err_vec   = r_first_err_vec;
   assign first_err_valid = r_first_err_valid;

endmodule

// File: doc/logic_sweep_checker.md
Name: logic_sweep_checker

Overview:
Parametrised self-checking exhaustive-sweep engine for an N_IN-input single-output combinational function. Drives every input vector 0 … 2^N_IN−1 onto an external function under test, samples its response and compares it against an expected truth table. Reports pass/fail, error count and the first failing vector. Sits beside gate-level logic blocks as a reusable on-chip/bench checker, replacing hand-written per-vector stimulus.

Parameters:
N_IN, 4, number of function inputs (1..8); vector space is 2^N_IN.
DWELL, 1, clock cycles each vector is held before sampling (>=1, covers settle time).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin a sweep; honoured in IDLE or DONE only.
abort  input  1  terminate sweep early; honoured in RUN only.
exp_tt  input  2^N_IN  expected truth table; bit i = expected f for vector i.
dut_f  input  1  response of the function under test to vec_out.
vec_out  output  N_IN  current input vector; bit0 = first input (a), bit1 = b, and so on.
busy  output  1  high while a sweep is running.
done  output  1  high (level) after a sweep completes; cleared by start or abort.
pass  output  1  valid while done: 1 iff err_cnt == 0.
err_cnt  output  N_IN+1  number of mismatching vectors (max 2^N_IN, no saturation needed).
first_err_vec  output  N_IN  index of the first mismatching vector.
first_err_valid  output  1  at least one mismatch recorded this sweep.

Behaviour:
- Reset (async assert, sync deassert at the flops' clock): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0; dwell counter=0; latched table=0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start: next cycle RUN. exp_tt latched into an internal register. vec_out=0, dwell=0, err_cnt=0, first_err_valid=0, first_err_vec=0, done=0, pass=0, busy=1.
- RUN:
  - vec_out held for DWELL cycles. dut_f is sampled in the last dwell cycle and compared with latched_tt[vec_out].
  - On mismatch, err_cnt increments. If first_err_valid==0, first_err_vec←vec_out and first_err_valid←1.
  - On sample of vector 2^N_IN−1: next cycle DONE, busy=0, done=1, pass=(final err_cnt==0). vec_out stays at the last vector.
  - Otherwise vec_out increments and dwell restarts.
- Latency: start sampled at edge t gives busy at t+1 and done at t+1+2^N_IN·DWELL.
- abort in RUN (priority over the sample on the same cycle; that vector is not counted): next cycle IDLE, busy=0, done=0, pass=0, vec_out=0. err_cnt, first_err_* retain partial values.
- start while RUN: ignored. abort in IDLE/DONE: ignored. start and abort together in RUN: abort wins.
- exp_tt changes during RUN have no effect (latched copy used).
- Reset mid-sweep: immediate return to reset values, no done pulse.
- vec_out wraps only by restart, never by counter overflow. Counter width N_IN+1 internally so terminal detection does not rely on wrap.

Decomposition:
- Package logic_sweep_pkg: state enum (IDLE, RUN, DONE), state width constant, helper localparam NVEC = 2^N_IN computed per instance.
- One sub-module, sweep_counter: vector counter + dwell counter, parametrised by N_IN and DWELL. Outputs vec, sample_en (last dwell cycle) and last (sample_en on final vector). Inputs clr and en.
- Top holds the FSM, latched table, compare and error bookkeeping.

Test Plan:
1. N_IN=4, DWELL=1, DUT f=(a^b)|(~a&c)|~(b&d), exp_tt=16'h77FF, start at t -> busy t+1..t+16, done=1 at t+17, pass=1, err_cnt=0, first_err_valid=0.
2. Same DUT, exp_tt=16'hFFFF -> done at t+17, pass=0, err_cnt=2, first_err_vec=4'd11, first_err_valid=1.
3. DWELL=3, exp_tt=16'h77FF -> vec_out steps every 3 cycles (0,0,0,1,1,1,…), done at t+49, pass=1. Corrupt exp_tt to 0 mid-sweep -> still pass=1.
4. Abort while vec_out=5 -> next cycle IDLE, busy=0, done=0, vec_out=0. err_cnt equals mismatches among vectors 0..4 only.
5. rst_n low while vec_out=9 -> all outputs zero in the same cycle with no clock edge needed. After release, a start performs a full clean sweep.
6. start pulses while busy -> ignored, done still at t+17. start while done=1 -> done drops next cycle, counters cleared, new sweep completes after 2^N_IN·DWELL further cycles.
